tiadc_frame_aligner: RTL and testbench

- Parametrised successor to the fixed 8-way, 3-stage latch retimer of the TI-SAR ADC wrapper.
- Collects per-way sub-ADC conversion results, checks that they arrive in interleave order, and applies optional bit reversal and offset-binary to two's-complement conversion.
- Packs one complete interleave frame into a wide word and buffers frames in a small FIFO with a valid/ready output towards the DSP core.
- Sits between the sub-ADC array (strobes already synchronised to clk) and the digital back-end.

---
 rtl/tiadc_frame_aligner.sv | 157 +++++++++++++++
 tb/tb_tiadc_frame_aligner.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tiadc_frame_aligner.sv
// Aligns per-way TI-SAR sub-ADC results into full interleave frames, with optional
// bit reversal / two's-complement conversion, and buffers them in a valid/ready FIFO.
module tiadc_frame_aligner #(
  parameter int ADC_WAYS   = 8,
  parameter int ADC_BITS   = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADC_WAYS*ADC_BITS-1:0] way_data,
  input  logic [ADC_WAYS-1:0]          way_strb,
  input  logic [ADC_WAYS-1:0]          way_mask,
  input  logic                         start,
  input  logic                         bit_rev,
  input  logic                         twos_comp,
  input  logic                         clr_err,
  output logic [ADC_WAYS*ADC_BITS-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CNT_W-1:0]             frame_cnt,
  output logic                         overflow,
  output logic                         err_order
);

  localparam int FW    = ADC_WAYS * ADC_BITS;
  localparam int WAY_W = $clog2(ADC_WAYS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SYNC, COLLECT, PUSH} state_t;

  state_t             state;
  logic [WAY_W-1:0]   exp_way;
  logic [FW-1:0]      stage;
  logic [FW-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [OCC_W-1:0]   occ;

  // Returns {found, index} of the lowest enabled way at or above 'from'.
  function automatic logic [WAY_W:0] find_way(input logic [ADC_WAYS-1:0] m, input int from);
    logic [WAY_W:0] r;
    r = '0;
    for (int i = ADC_WAYS - 1; i >= 0; i--)
      if (i >= from && m[i]) r = {1'b1, WAY_W'(i)};
    return r;
  endfunction

  // Sub-ADC bit 0 is the MSB; after optional reversal the MSB sits at ADC_BITS-1.
  function automatic logic [ADC_BITS-1:0] xform(input logic [ADC_BITS-1:0] s,
                                                input logic rev, input logic tc);
    logic [ADC_BITS-1:0] r;
    for (int i = 0; i < ADC_BITS; i++) r[i] = rev ? s[ADC_BITS-1-i] : s[i];
    if (tc) begin
      if (rev) r[ADC_BITS-1] = ~r[ADC_BITS-1];
      else     r[0]          = ~r[0];
    end
    return r;
  endfunction

  logic [WAY_W:0]      first_way, next_way;
  logic [ADC_BITS-1:0] sample;
  logic [ADC_WAYS-1:0] exp_onehot;
  logic                fifo_full, push_ok, order_evt, ovf_evt, pop, load;
  logic [OCC_W-1:0]    mem_cnt;

  assign first_way  = find_way(way_mask, 0);
  assign next_way   = find_way(way_mask, int'(exp_way) + 1);
  assign sample     = xform(way_data[int'(exp_way)*ADC_BITS +: ADC_BITS], bit_rev, twos_comp);
  assign exp_onehot = ADC_WAYS'(1) << exp_way;
  // Occupancy includes the output register; a same-cycle pop does not free space.
  assign fifo_full  = (occ == OCC_W'(FIFO_DEPTH));
  assign push_ok    = start && (state == PUSH) && !fifo_full;
  assign ovf_evt    = start && (state == PUSH) && fifo_full;
  assign order_evt  = start && (state == COLLECT) && (way_strb != '0) && (way_strb != exp_onehot);
  assign pop        = out_valid && out_ready;
  assign mem_cnt    = occ - OCC_W'(out_valid);
  assign load       = (mem_cnt != '0) && (!out_valid || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      exp_way   <= '0;
      stage     <= '0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
      err_order <= 1'b0;
    end else begin
      // A new error event wins over a simultaneous clear.
      if (order_evt)    err_order <= 1'b1;
      else if (clr_err) err_order <= 1'b0;
      if (ovf_evt)      overflow  <= 1'b1;
      else if (clr_err) overflow  <= 1'b0;

      if (!start) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: if (first_way[WAY_W]) begin
            state   <= SYNC;
            exp_way <= first_way[WAY_W-1:0];
          end
          SYNC: if (way_strb[exp_way]) begin
            stage <= '0;
            stage[int'(exp_way)*ADC_BITS +: ADC_BITS] <= sample;
            if (next_way[WAY_W]) begin
              state   <= COLLECT;
              exp_way <= next_way[WAY_W-1:0];
            end else begin
              state <= PUSH;
            end
          end
          COLLECT: if (way_strb == exp_onehot) begin
            stage[int'(exp_way)*ADC_BITS +: ADC_BITS] <= sample;
            if (next_way[WAY_W]) exp_way <= next_way[WAY_W-1:0];
            else                 state   <= PUSH;
          end else if (way_strb != '0) begin
            state   <= SYNC;
            exp_way <= first_way[WAY_W-1:0];
          end
          PUSH: begin
            state   <= SYNC;
            exp_way <= first_way[WAY_W-1:0];
            if (push_ok) frame_cnt <= frame_cnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: the frame storage has no reset; occupancy and pointers alone decide what is readable.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= stage;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      occ <= occ + OCC_W'(push_ok) - OCC_W'(pop);
      if (load) begin
        out_data  <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tiadc_frame_aligner.sv
// Self-checking bench: frame-level reference model plus directed scenarios with literal expectations.
module tb_tiadc_frame_aligner;

  localparam int W  = 8;
  localparam int B  = 9;
  localparam int D  = 4;
  localparam int CW = 16;
  localparam int FW = W * B;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] way_data;
  logic [W-1:0]  way_strb, way_mask;
  logic          start, bit_rev, twos_comp, clr_err, out_ready;
  logic [FW-1:0] out_data;
  logic          out_valid, overflow, err_order;
  logic [CW-1:0] frame_cnt;

  tiadc_frame_aligner #(.ADC_WAYS(W), .ADC_BITS(B), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .way_data(way_data), .way_strb(way_strb), .way_mask(way_mask),
    .start(start), .bit_rev(bit_rev), .twos_comp(twos_comp), .clr_err(clr_err),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_cnt(frame_cnt), .overflow(overflow), .err_order(err_order)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pop    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: a frame is the list of enabled ways received in ascending order.
  typedef struct { logic [FW-1:0] data; int avail; } mframe_t;
  mframe_t       mq[$];
  int            m_cyc = 0;
  int            m_pos = 0;
  bit            m_armed, m_gap, m_ovf, m_err, m_valid, m_live;
  logic [CW-1:0] m_cnt;
  logic [FW-1:0] m_part;

  function automatic logic [B-1:0] xf(input logic [B-1:0] s, input bit rev, input bit tc);
    logic [B-1:0] r;
    for (int i = 0; i < B; i++) r[i] = rev ? s[B-1-i] : s[i];
    if (tc) begin
      if (rev) r[B-1] = ~r[B-1];
      else     r[0]   = ~r[0];
    end
    return r;
  endfunction

  always @(posedge clk) begin : model
    int en[$];
    bit pop_now, err_evt, ovf_evt, done;
    en = {};
    for (int i = 0; i < W; i++) if (way_mask[i]) en.push_back(i);
    pop_now = m_valid && out_ready;
    err_evt = 0; ovf_evt = 0; done = 0;
    m_cyc++;
    if (rst) begin
      mq.delete();
      m_armed = 0; m_gap = 0; m_pos = 0; m_cnt = '0;
      m_ovf = 0; m_err = 0; m_live = 1; m_part = '0;
    end else begin
      if (!start) begin
        m_armed = 0; m_gap = 0; m_pos = 0;
      end else if (!m_armed) begin
        m_armed = (en.size() != 0); m_pos = 0;
      end else if (m_gap) begin
        m_gap = 0;
        if (mq.size() < D) begin
          mq.push_back('{data: m_part, avail: m_cyc + 1});
          m_cnt = m_cnt + 1'b1;
        end else ovf_evt = 1;
      end else if (m_pos == 0) begin
        if (way_strb[en[0]]) begin
          m_part = '0;
          m_part[en[0]*B +: B] = xf(way_data[en[0]*B +: B], bit_rev, twos_comp);
          m_pos = 1; done = (en.size() == 1);
        end
      end else if (way_strb != '0) begin
        if (way_strb == (W'(1) << en[m_pos])) begin
          m_part[en[m_pos]*B +: B] = xf(way_data[en[m_pos]*B +: B], bit_rev, twos_comp);
          m_pos++; done = (m_pos == en.size());
        end else begin
          err_evt = 1; m_pos = 0;
        end
      end
      if (done) begin m_gap = 1; m_pos = 0; end
      if (pop_now) void'(mq.pop_front());
      if (clr_err) begin m_err = 0; m_ovf = 0; end
      if (err_evt) m_err = 1;
      if (ovf_evt) m_ovf = 1;
    end
    m_valid = (mq.size() > 0) && (mq[0].avail <= m_cyc);
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("out_valid", 128'(out_valid), 128'(m_valid));
      if (m_valid) check("out_data", 128'(out_data), 128'(mq[0].data));
      check("frame_cnt", 128'(frame_cnt), 128'(m_cnt));
      check("overflow", 128'(overflow), 128'(m_ovf));
      check("err_order", 128'(err_order), 128'(m_err));
    end
  end

  always @(posedge clk) if (!rst && out_valid && out_ready) n_pop++;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int w, input logic [B-1:0] d);
    for (int i = 0; i < W; i++) way_data[i*B +: B] = B'($urandom);
    way_data[w*B +: B] = d;
    way_strb = W'(1) << w;
    tick();
    way_strb = '0;
  endtask

  task automatic rearm(input logic [W-1:0] m);
    start = 1'b0; tick();
    way_mask = m; start = 1'b1; tick();
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
  endtask

  logic [FW-1:0] exp_frame;

  initial begin
    rst = 1'b1; way_data = '0; way_strb = '0; way_mask = '0; start = 1'b0;
    bit_rev = 1'b0; twos_comp = 1'b0; clr_err = 1'b0; out_ready = 1'b1;
    tick(2);
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_cnt", 128'(frame_cnt), 128'(0));
    check("rst_flags", 128'({overflow, err_order}), 128'(0));
    rst = 1'b0; tick();

    // Ordered frame and latency
    rearm(8'hFF);
    for (int i = 0; i < 8; i++) send(i, B'(i + 1));
    check("lat_k0", 128'(out_valid), 128'(0));
    tick();
    check("lat_k1", 128'(out_valid), 128'(0));
    tick();
    for (int i = 0; i < 8; i++) exp_frame[i*B +: B] = B'(i + 1);
    check("lat_k2", 128'(out_valid), 128'(1));
    check("ordered_data", 128'(out_data), 128'(exp_frame));
    check("ordered_cnt", 128'(frame_cnt), 128'(1));
    tick(2);

    // Transform
    bit_rev = 1'b1; twos_comp = 1'b1;
    rearm(8'h01);
    send(0, 9'b000000001);
    tick(2);
    check("xform_valid", 128'(out_valid), 128'(1));
    check("xform_zero", 128'(out_data), 128'(0));
    send(0, 9'b001010011);
    tick(2);
    check("xform_094", 128'(out_data), 128'(9'h094));
    tick(2);
    bit_rev = 1'b0; twos_comp = 1'b0;

    // Order error, lock, sticky behaviour
    rearm(8'hFF);
    send(3, 9'h033); send(0, 9'h000); send(1, 9'h011);
    check("err_before", 128'(err_order), 128'(0));
    send(4, 9'h044);
    check("err_at_4", 128'(err_order), 128'(1));
    for (int i = 0; i < 8; i++) send(i, B'(16 * i + 3));
    tick(3);
    check("err_lock_cnt", 128'(frame_cnt), 128'(4));
    check("err_sticky", 128'(err_order), 128'(1));
    pulse_clr();
    check("err_cleared", 128'(err_order), 128'(0));
    send(0, 9'h001);
    clr_err = 1'b1;
    send(2, 9'h002);
    clr_err = 1'b0;
    check("err_set_wins", 128'(err_order), 128'(1));
    pulse_clr();

    // Overflow and back-pressure
    out_ready = 1'b0;
    rearm(8'hFF);
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 8; i++) send(i, B'(32 * f + i));
      tick();
    end
    for (int i = 0; i < 8; i++) exp_frame[i*B +: B] = B'(i);
    check("ovf_flag", 128'(overflow), 128'(1));
    check("ovf_cnt", 128'(frame_cnt), 128'(8));
    check("ovf_held", 128'(out_data), 128'(exp_frame));
    n_pop = 0;
    out_ready = 1'b1;
    tick(10);
    check("ovf_drained", 128'(n_pop), 128'(4));
    check("ovf_empty", 128'(out_valid), 128'(0));
    pulse_clr();

    // Masked ways
    rearm(8'hA5);
    send(0, 9'h011); send(2, 9'h022); send(5, 9'h055); send(7, 9'h077);
    tick(2);
    exp_frame = '0;
    exp_frame[0*B +: B] = 9'h011; exp_frame[2*B +: B] = 9'h022;
    exp_frame[5*B +: B] = 9'h055; exp_frame[7*B +: B] = 9'h077;
    check("mask_data", 128'(out_data), 128'(exp_frame));
    tick(2);
    send(0, 9'h001); send(1, 9'h001);
    check("mask_err", 128'(err_order), 128'(1));
    pulse_clr();

    // Abort
    rearm(8'hFF);
    send(0, 9'h001); send(1, 9'h002); send(2, 9'h003);
    start = 1'b0; tick(3);
    check("abort_err", 128'(err_order), 128'(0));
    check("abort_cnt", 128'(frame_cnt), 128'(9));

    // Reset mid-frame with frames queued
    out_ready = 1'b0;
    rearm(8'hFF);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) send(i, B'(64 + 8 * f + i));
      tick();
    end
    send(0, 9'h001); send(3, 9'h003);
    send(0, 9'h001); send(1, 9'h002); send(2, 9'h003);
    check("pre_rst_valid", 128'(out_valid), 128'(1));
    rst = 1'b1; tick();
    check("rst_mid_valid", 128'(out_valid), 128'(0));
    check("rst_mid_cnt", 128'(frame_cnt), 128'(0));
    check("rst_mid_flags", 128'({overflow, err_order}), 128'(0));
    rst = 1'b0; start = 1'b0; out_ready = 1'b1;
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
